// File: rtl/wb_buffer_pkg.sv
// wb_buffer_pkg: shared FSM encoding and default sizing for the write-back buffer
// Ports: none (package only)
package wb_buffer_pkg;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;
endpackage

// File: rtl/wb_match.sv
// wb_match: combinational lookup returning hit and the youngest matching entry index
// Ports: tags_i/valid_i entry word-tags and valids, head_i oldest index,
//        tag_i lookup word-tag, hit_o any match, idx_o youngest matching index
module wb_match
   import wb_buffer_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int TW = DEF_ADDR_W - 2,
   localparam int LW = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][TW-1:0] tags_i,
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [LW-1:0]            head_i,
   input  logic [TW-1:0]            tag_i,
   output logic                     hit_o,
   output logic [LW-1:0]            idx_o
);
   // Walk from head (oldest) towards tail so the last hit is the youngest.
   always_comb begin
      hit_o = 1'b0;
      idx_o = head_i;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_i[head_i + LW'(k)] && tags_i[head_i + LW'(k)] == tag_i) begin
            hit_o = 1'b1;
            idx_o = head_i + LW'(k);
         end
      end
   end
endmodule

// File: rtl/wb_buffer.sv
// wb_buffer: write-back buffer with coalescing, read hit forwarding and miss fills
// Ports: clk, rst (async active-low); wr_en/wr_addr/wr_data write-back in;
//        rd_req/rd_addr fill request, rd_data/rd_valid fill response;
//        full/empty/err status; mem_we/mem_re/mem_addr/mem_wdata/mem_rdata/mem_ack memory side
module wb_buffer
   import wb_buffer_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              err,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int LW = $clog2(DEPTH);
   localparam int TW = ADDR_W - 2;
   state_t                      state_q;
   logic [DEPTH-1:0][TW-1:0]     tag_q;
   logic [DEPTH-1:0][DATA_W-1:0] data_q;
   logic [DEPTH-1:0]             vld_q, wvld;
   logic [LW-1:0]                head_q, tail_q, widx, ridx;
   logic [LW:0]                  cnt_q, cnt_d;
   logic [TW-1:0]                rtag_q, wtag, rtag;
   logic [ADDR_W-1:0]            mem_addr_q;
   logic [DATA_W-1:0]            mem_wdata_q, rd_data_q, hit_data, head_wdata;
   logic err_q, pend_q, mem_we_q, mem_re_q, rd_valid_q;
   logic whit, rhit, coal, enq, drop, pop, rd_acc, fwd, rd_hit, rd_miss;
   logic unused_lsb;
   assign unused_lsb = ^{wr_addr[1:0], rd_addr[1:0]};
   assign wtag = wr_addr[ADDR_W-1:2];
   assign rtag = rd_addr[ADDR_W-1:2];
   // The head being drained is on the memory bus and must not change under it.
   assign wvld = vld_q & ~((state_q == DRAIN) ? (DEPTH'(1) << head_q) : '0);
   wb_match #(.DEPTH(DEPTH), .TW(TW)) u_wmatch (
      .tags_i(tag_q), .valid_i(wvld), .head_i(head_q), .tag_i(wtag), .hit_o(whit), .idx_o(widx)
   );
   wb_match #(.DEPTH(DEPTH), .TW(TW)) u_rmatch (
      .tags_i(tag_q), .valid_i(vld_q), .head_i(head_q), .tag_i(rtag), .hit_o(rhit), .idx_o(ridx)
   );
   assign full  = cnt_q == (LW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign coal  = wr_en && whit;
   assign enq   = wr_en && !whit && !full;
   assign drop  = wr_en && !whit && full;
   assign pop   = state_q == DRAIN && mem_ack;
   assign cnt_d = cnt_q + (LW+1)'(enq) - (LW+1)'(pop);
   assign rd_acc  = rd_req && !pend_q && state_q != READ;
   assign fwd     = (coal || enq) && wtag == rtag;
   assign rd_hit  = rd_acc && (fwd || rhit);
   assign rd_miss = rd_acc && !fwd && !rhit;
   assign hit_data = fwd ? wr_data : data_q[ridx];
   // A coalesce into the head on the edge that starts its drain must reach memory.
   assign head_wdata = (coal && widx == head_q) ? wr_data : data_q[head_q];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         data_q      <= '0;
         vld_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         rtag_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         if (coal) data_q[widx] <= wr_data;
         if (enq) begin
            tag_q[tail_q]  <= wtag;
            data_q[tail_q] <= wr_data;
            vld_q[tail_q]  <= 1'b1;
            tail_q         <= tail_q + 1'b1;
         end
         if (pop) begin
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + 1'b1;
         end
         cnt_q <= cnt_d;
         if (drop) err_q <= 1'b1;
         if (rd_miss) begin
            pend_q <= 1'b1;
            rtag_q <= rtag;
         end
         rd_valid_q <= rd_hit;
         if (rd_hit) rd_data_q <= hit_data;
         case (state_q)
            IDLE:
               if (pend_q) begin
                  state_q    <= READ;
                  pend_q     <= 1'b0;
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= {rtag_q, 2'b00};
               end else if (!empty) begin
                  state_q     <= DRAIN;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {tag_q[head_q], 2'b00};
                  mem_wdata_q <= head_wdata;
               end
            DRAIN:
               if (mem_ack) begin
                  state_q  <= IDLE;
                  mem_we_q <= 1'b0;
               end
            READ:
               if (mem_ack) begin
                  state_q    <= RESP;
                  mem_re_q   <= 1'b0;
                  rd_valid_q <= 1'b1;
                  rd_data_q  <= mem_rdata;
               end
            RESP: state_q <= IDLE;
         endcase
      end
   end
   assign err       = err_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_wb_buffer.sv
// tb_wb_buffer: directed self-checking bench for wb_buffer
// Ports: none (top-level bench)
module tb_wb_buffer;
   logic        clk = 1'b0, rst, wr_en, rd_req, mem_ack;
   logic [15:0] wr_addr, rd_addr, mem_addr;
   logic [31:0] wr_data, mem_rdata, rd_data, mem_wdata;
   logic        rd_valid, full, empty, err, mem_we, mem_re;
   logic        saw_re = 1'b0, saw_rv = 1'b0;
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   wb_buffer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .full(full), .empty(empty), .err(err), .mem_we(mem_we), .mem_re(mem_re),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );
   always @(negedge clk) begin
      if (mem_re) saw_re = 1'b1;
      if (rd_valid) saw_rv = 1'b1;
      if (rst) begin
         n_chk++;
         if (mem_we && mem_re) begin n_fail++; $display("FAIL we_re_exclusive: mem_we=%b mem_re=%b, required not both 1", mem_we, mem_re); end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in;
      wr_en = 0; rd_req = 0; mem_ack = 0; wr_addr = 0; rd_addr = 0; wr_data = 0; mem_rdata = 0;
   endtask
   task automatic do_reset;
      idle_in();
      rst = 0;
      tick();
      tick();
      rst = 1;
      tick();
   endtask
   task automatic write(input logic [15:0] a, input logic [31:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 0;
   endtask
   task automatic test_reset;
      idle_in();
      rst = 0;
      tick();
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      n_chk++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re: got %b want 0", mem_re); end
      n_chk++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_chk++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      n_chk++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
   endtask
   task automatic test_drain;
      do_reset();
      write(16'h0040, 32'hDEADBEEF);
      n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL drain_queued: empty got %b want 0", empty); end
      tick();
      n_chk++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL drain_we: got %b want 1", mem_we); end
      n_chk++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL drain_addr: got %h want 0040", mem_addr); end
      n_chk++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL drain_wdata: got %h want deadbeef", mem_wdata); end
      mem_ack = 1;
      tick();
      mem_ack = 0;
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL drain_we_done: got %b want 0", mem_we); end
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
   endtask
   task automatic test_full;
      logic [15:0] exp_a [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
      int n = 0;
      do_reset();
      for (int i = 0; i < 4; i++) write(exp_a[i], 32'(i + 1));
      n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", full); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_no_err: got %b want 0", err); end
      write(16'h0050, 32'h5);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b want 1", err); end
      n_chk++; if (mem_we !== 1'b1 || mem_addr !== 16'h0010) begin n_fail++; $display("FAIL full_head_hold: we=%b addr=%h want 1 0010", mem_we, mem_addr); end
      mem_ack = 1;
      for (int i = 0; i < 20 && !empty; i++) begin
         if (mem_we) begin
            n_chk++; if (n > 3 || mem_addr !== exp_a[n]) begin n_fail++; $display("FAIL full_drain_order: drain %0d addr %h", n, mem_addr); end
            n++;
         end
         tick();
      end
      mem_ack = 0;
      n_chk++; if (n !== 4) begin n_fail++; $display("FAIL full_drain_count: got %0d want 4", n); end
      n_chk++; if (empty !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL full_after: empty=%b err=%b want 1 1", empty, err); end
   endtask
   task automatic test_coalesce;
      int n80 = 0;
      do_reset();
      saw_re = 0;
      write(16'h0200, 32'hAAAAAAAA);
      write(16'h0080, 32'h11111111);
      n_chk++; if (mem_we !== 1'b1 || mem_addr !== 16'h0200) begin n_fail++; $display("FAIL coal_head_drain: we=%b addr=%h want 1 0200", mem_we, mem_addr); end
      write(16'h0081, 32'h22222222);
      rd_req = 1; rd_addr = 16'h0082;
      tick();
      rd_req = 0;
      n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL coal_rd_valid: got %b want 1", rd_valid); end
      n_chk++; if (rd_data !== 32'h22222222) begin n_fail++; $display("FAIL coal_rd_data: got %h want 22222222", rd_data); end
      tick();
      n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL coal_rd_pulse: got %b want 0", rd_valid); end
      write(16'h0300, 32'h3);
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL coal_count3: full got %b want 0", full); end
      write(16'h0400, 32'h4);
      n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL coal_count4: full got %b want 1", full); end
      n_chk++; if (saw_re !== 1'b0) begin n_fail++; $display("FAIL coal_no_mem_re: saw %b want 0", saw_re); end
      mem_ack = 1;
      for (int i = 0; i < 20 && !empty; i++) begin
         if (mem_we && mem_addr == 16'h0080) begin
            n80++;
            n_chk++; if (mem_wdata !== 32'h22222222) begin n_fail++; $display("FAIL coal_mem_wdata: got %h want 22222222", mem_wdata); end
         end
         tick();
      end
      mem_ack = 0;
      n_chk++; if (n80 !== 1 || empty !== 1'b1) begin n_fail++; $display("FAIL coal_drain: writes to 0080 %0d empty %b want 1 1", n80, empty); end
   endtask
   task automatic test_miss;
      int re_cyc = 0;
      do_reset();
      rd_req = 1; rd_addr = 16'h0100;
      tick();
      rd_req = 0;
      tick();
      n_chk++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100) begin n_fail++; $display("FAIL miss_issue: re=%b we=%b addr=%h want 1 0 0100", mem_re, mem_we, mem_addr); end
      for (int i = 0; i < 9; i++) begin
         if (mem_re) re_cyc++;
         if (i == 3) begin rd_req = 1; rd_addr = 16'h0200; end
         tick();
         rd_req = 0;
      end
      if (mem_re) re_cyc++;
      mem_ack = 1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 0; mem_rdata = 0;
      n_chk++; if (re_cyc !== 10) begin n_fail++; $display("FAIL miss_re_cycles: got %0d want 10", re_cyc); end
      n_chk++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL miss_re_drop: got %b want 0", mem_re); end
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL miss_resp: valid=%b data=%h want 1 cafef00d", rd_valid, rd_data); end
      tick();
      n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL miss_pulse: got %b want 0", rd_valid); end
      saw_re = 0;
      repeat (4) tick();
      n_chk++; if (saw_re !== 1'b0) begin n_fail++; $display("FAIL miss_second_ignored: mem_re seen %b want 0", saw_re); end
   endtask
   task automatic test_drain_read;
      do_reset();
      write(16'h0400, 32'h12345678);
      tick();
      rd_req = 1; rd_addr = 16'h0500;
      tick();
      rd_req = 0;
      n_chk++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL dr_drain_kept: we=%b re=%b want 1 0", mem_we, mem_re); end
      tick();
      mem_ack = 1;
      tick();
      mem_ack = 0;
      n_chk++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL dr_gap: we=%b re=%b want 0 0", mem_we, mem_re); end
      tick();
      n_chk++; if (mem_re !== 1'b1 || mem_addr !== 16'h0500) begin n_fail++; $display("FAIL dr_read: re=%b addr=%h want 1 0500", mem_re, mem_addr); end
      mem_ack = 1; mem_rdata = 32'h55AA55AA;
      tick();
      mem_ack = 0; mem_rdata = 0;
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 32'h55AA55AA) begin n_fail++; $display("FAIL dr_resp: valid=%b data=%h want 1 55aa55aa", rd_valid, rd_data); end
   endtask
   task automatic test_forward;
      do_reset();
      wr_en = 1; wr_addr = 16'h0600; wr_data = 32'h600D600D;
      rd_req = 1; rd_addr = 16'h0600;
      tick();
      wr_en = 0; rd_req = 0;
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 32'h600D600D) begin n_fail++; $display("FAIL fwd_resp: valid=%b data=%h want 1 600d600d", rd_valid, rd_data); end
      n_chk++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL fwd_no_mem: re=%b want 0", mem_re); end
   endtask
   task automatic test_reset_read;
      do_reset();
      rd_req = 1; rd_addr = 16'h0700;
      tick();
      rd_req = 0;
      tick();
      n_chk++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rr_reading: re=%b want 1", mem_re); end
      for (int i = 1; i <= 5; i++) write(16'(i * 16), 32'(i));
      n_chk++; if (err !== 1'b1 || full !== 1'b1) begin n_fail++; $display("FAIL rr_pre: err=%b full=%b want 1 1", err, full); end
      rst = 0;
      #1;
      n_chk++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rr_re_drop: got %b want 0", mem_re); end
      n_chk++; if (empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rr_flags: empty=%b full=%b err=%b want 1 0 0", empty, full, err); end
      saw_rv = 0;
      mem_ack = 1; mem_rdata = 32'hBADBAD00;
      tick();
      tick();
      rst = 1;
      repeat (3) tick();
      mem_ack = 0;
      n_chk++; if (saw_rv !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL rr_no_resp: rd_valid seen %b re=%b want 0 0", saw_rv, mem_re); end
   endtask
   initial begin
      test_reset();
      test_drain();
      test_full();
      test_coalesce();
      test_miss();
      test_drain_read();
      test_forward();
      test_reset_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, number of buffered write-back entries (power of 2, 2..8).
REQ-002 Parameters SHALL be: ADDR_W, 16, byte-address width; DATA_W, 32, word width.
REQ-003 Ports SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-004 Ports SHALL be: rst  in  1  asynchronous, active-low reset.
REQ-005 Ports SHALL be: wr_en  in  1  cache write-back request; wr_addr  in  ADDR_W; wr_data  in  DATA_W.
REQ-006 Ports SHALL be: rd_req  in  1  cache line-fill read request; rd_addr  in  ADDR_W.
REQ-007 Ports SHALL be: rd_data  out  DATA_W  fill data; rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-008 Ports SHALL be: full  out  1  no free entry; empty  out  1  no entry queued; err  out  1  sticky overflow flag.
REQ-009 Ports SHALL be: mem_we  out  1; mem_re  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W.
REQ-010 Ports SHALL be: mem_rdata  in  DATA_W; mem_ack  in  1  memory completes current we/re this cycle.

Function
REQ-011 Addresses SHALL be compared on bits [ADDR_W-1:2] only; bits [1:0] ignored, mem_addr bits [1:0] driven 0.
REQ-012 Storage SHALL be a DEPTH-entry circular FIFO (head/tail pointers wrap modulo DEPTH, count 0..DEPTH).
REQ-013 wr_en with !full and no address match SHALL enqueue {wr_addr, wr_data} at tail on the same edge.
REQ-014 wr_en matching a queued entry other than the head currently being drained SHALL overwrite that entry's data in place; count unchanged (coalesce).
REQ-015 wr_en while full and no coalesce possible SHALL drop the write and set err; err clears only on reset.
REQ-016 full/empty SHALL be decoded from registered count; an enqueue refused at full is not retried even if the head retires that cycle.
REQ-017 rd_req matching a queued entry SHALL return the youngest matching entry's data with rd_valid exactly 1 cycle later; no memory access.
REQ-018 rd_req with wr_en same cycle and same address SHALL forward wr_data (write applied first).
REQ-019 rd_req with no match SHALL be latched and serviced via memory; rd_valid pulses the cycle after mem_ack with rd_data = mem_rdata captured at mem_ack.
REQ-020 Only one outstanding rd_req SHALL be accepted; a further rd_req before its rd_valid is ignored.
REQ-021 FSM states SHALL be IDLE, DRAIN, READ, RESP.
REQ-022 IDLE: pending miss-read -> READ (priority); else !empty -> DRAIN; else stay.
REQ-023 DRAIN: mem_we=1, mem_addr/mem_wdata = head; hold until mem_ack, then pop head -> IDLE.
REQ-024 READ: mem_re=1, mem_addr = latched rd_addr; hold until mem_ack -> RESP.
REQ-025 RESP: rd_valid=1 for one cycle -> IDLE.
REQ-026 A drain in progress SHALL NOT be aborted by rd_req; the read waits for the drain's mem_ack.
REQ-027 mem_we and mem_re SHALL never be asserted together; request signals SHALL be stable until mem_ack.
REQ-028 A miss-read SHALL only go to memory after any queued entry with a matching address has been checked (REQ-017 takes priority, so memory never returns stale data).

Reset
REQ-029 rst low SHALL immediately force: FSM IDLE, count/head/tail 0, all entries invalid, err 0.
REQ-030 Output reset values SHALL be: mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, rd_data 0, rd_valid 0, full 0, empty 1.
REQ-031 Reset mid-DRAIN or mid-READ SHALL discard the transaction; no rd_valid is produced for it.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and default DEPTH/ADDR_W/DATA_W constants.
REQ-033 One sub-module wb_match SHALL take all entry addresses/valids plus a lookup address and return hit and youngest-hit index (combinational).

Verification
REQ-034 Reset, then wr_en addr 0x0040 data 0xDEADBEEF -> entry queued, DRAIN issues mem_we addr 0x0040 wdata 0xDEADBEEF, empty=1 after mem_ack.
REQ-035 mem_ack held low; enqueue 0x0010,0x0020,0x0030,0x0040 -> full=1; fifth wr_en 0x0050 -> dropped, err=1.
REQ-036 Queue 0x0080=0x11111111 then 0x0080=0x22222222 (head draining other address) -> count unchanged, rd_req 0x0080 -> rd_valid next cycle, rd_data 0x22222222, mem_re never asserted.
REQ-037 rd_req 0x0100 with mem_ack after 10 cycles, mem_rdata 0xCAFEF00D -> mem_re held 10 cycles, rd_valid one cycle later with 0xCAFEF00D.
REQ-038 rd_req arrives during DRAIN -> mem_we completes first, then mem_re; never both high.
REQ-039 rst low during READ -> mem_re drops same cycle, no rd_valid, empty=1, err=0.
